// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipeline control unit: opcodes, ALU op codes,
// the per-stage control word and the halt state machine encoding.
package ctrl_pkg;

    localparam logic [6:0] OpcR      = 7'b0110011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcImm    = 7'b0010011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcSystem = 7'b1110011;

    // funct7 value that marks an RV32M multiply/divide R-type
    localparam logic [6:0] F7MulDiv  = 7'b0000001;

    typedef enum logic [2:0] {
        AluAdd    = 3'b000,
        AluBranch = 3'b001,
        AluR      = 3'b010,
        AluI      = 3'b011,
        AluMulDiv = 3'b100
    } alu_op_e;

    typedef enum logic [1:0] {
        HaltRun    = 2'b00,
        HaltDrain  = 2'b01,
        HaltHalted = 2'b10
    } halt_state_e;

    // Control word carried ID/EX -> EX/MEM -> MEM/WB. halt marks an ecall that
    // had halt_req=1 when it was decoded; it only matters while in EX.
    typedef struct packed {
        logic       alu_src;
        logic       branch;
        logic       is_jal;
        logic       is_jalr;
        alu_op_e    alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       wb_write_enable;
        logic       wb_mem_to_reg;
        logic       wb_pc_to_reg;
        logic [4:0] rd;
        logic       halt;
    } ctrl_word_t;

    localparam ctrl_word_t CtrlBubble = '{alu_op: AluAdd, default: '0};

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational instruction decoder: produces the control word, which source
// registers the instruction reads, and whether a valid instruction is illegal.
module ctrl_decoder
    import ctrl_pkg::*;
#(
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [31:0] i_inst,
    input  logic        i_valid,
    input  logic        i_halt_req,
    output ctrl_word_t  o_ctrl,
    output logic        o_use_rs1,
    output logic        o_use_rs2,
    output logic        o_illegal
);

    logic [6:0] w_opcode;
    logic [4:0] w_rd;
    logic [6:0] w_funct7;
    logic       w_is_muldiv;
    logic       w_unused_inst;

    assign w_opcode      = i_inst[6:0];
    assign w_rd          = i_inst[11:7];
    assign w_funct7      = i_inst[31:25];
    assign w_is_muldiv   = (w_funct7 == F7MulDiv);
    // funct3 and the register specifiers are not needed to build the control word
    assign w_unused_inst = ^i_inst[24:12];

    // Decode opcode class into control bits; invalid slots decode as a bubble.
    always_comb begin
        o_ctrl    = CtrlBubble;
        o_use_rs1 = 1'b0;
        o_use_rs2 = 1'b0;
        o_illegal = 1'b0;
        if (i_valid) begin
            case (w_opcode)
                OpcR: begin
                    if (w_is_muldiv && !ENABLE_M) begin
                        o_illegal = 1'b1;
                    end else begin
                        if (w_is_muldiv) begin
                            o_ctrl.alu_op = AluMulDiv;
                        end else begin
                            o_ctrl.alu_op = AluR;
                        end
                        o_ctrl.wb_write_enable = 1'b1;
                        o_ctrl.rd              = w_rd;
                        o_use_rs1              = 1'b1;
                        o_use_rs2              = 1'b1;
                    end
                end
                OpcLoad: begin
                    o_ctrl.alu_src         = 1'b1;
                    o_ctrl.alu_op          = AluAdd;
                    o_ctrl.mem_read        = 1'b1;
                    o_ctrl.wb_write_enable = 1'b1;
                    o_ctrl.wb_mem_to_reg   = 1'b1;
                    o_ctrl.rd              = w_rd;
                    o_use_rs1              = 1'b1;
                end
                OpcStore: begin
                    // rd bits hold part of the store offset, so no destination
                    o_ctrl.alu_src   = 1'b1;
                    o_ctrl.alu_op    = AluAdd;
                    o_ctrl.mem_write = 1'b1;
                    o_use_rs1        = 1'b1;
                    o_use_rs2        = 1'b1;
                end
                OpcImm: begin
                    o_ctrl.alu_src         = 1'b1;
                    o_ctrl.alu_op          = AluI;
                    o_ctrl.wb_write_enable = 1'b1;
                    o_ctrl.rd              = w_rd;
                    o_use_rs1              = 1'b1;
                end
                OpcBranch: begin
                    o_ctrl.branch = 1'b1;
                    o_ctrl.alu_op = AluBranch;
                    o_use_rs1     = 1'b1;
                    o_use_rs2     = 1'b1;
                end
                OpcJalr: begin
                    o_ctrl.alu_src         = 1'b1;
                    o_ctrl.is_jalr         = 1'b1;
                    o_ctrl.alu_op          = AluAdd;
                    o_ctrl.wb_write_enable = 1'b1;
                    o_ctrl.wb_pc_to_reg    = 1'b1;
                    o_ctrl.rd              = w_rd;
                    o_use_rs1              = 1'b1;
                end
                OpcJal: begin
                    // target is pc + immediate, so the immediate operand is selected
                    o_ctrl.alu_src         = 1'b1;
                    o_ctrl.is_jal          = 1'b1;
                    o_ctrl.alu_op          = AluAdd;
                    o_ctrl.wb_write_enable = 1'b1;
                    o_ctrl.wb_pc_to_reg    = 1'b1;
                    o_ctrl.rd              = w_rd;
                end
                OpcSystem: begin
                    // ecall travels as a bubble; only a halting one is tagged
                    o_ctrl.halt = i_halt_req;
                end
                default: begin
                    o_illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: decodes ID, carries control words down ID/EX, EX/MEM
// and MEM/WB, handles load-use stalls, flushes, memory stalls, the ecall halt
// drain and the sticky illegal-instruction flag.
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter bit          ENABLE_M   = 1'b0,
    parameter int unsigned HALT_DRAIN = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] id_inst,
    input  logic        id_valid,
    input  logic        mem_stall,
    input  logic        flush,
    input  logic        halt_req,
    output logic        ex_alu_src,
    output logic        ex_branch,
    output logic        ex_is_jal,
    output logic        ex_is_jalr,
    output logic [2:0]  ex_alu_op,
    output logic        mem_read,
    output logic        mem_write,
    output logic        wb_write_enable,
    output logic        wb_mem_to_reg,
    output logic        wb_pc_to_reg,
    output logic [4:0]  ex_rd,
    output logic [4:0]  mem_rd,
    output logic [4:0]  wb_rd,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        is_halted,
    output logic        illegal_inst
);

    localparam int unsigned CntW = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;

    ctrl_word_t     w_id_ctrl;
    logic           w_use_rs1;
    logic           w_use_rs2;
    logic           w_illegal;
    logic           w_load_use;
    logic           w_set_illegal;
    logic           w_pc_write;
    ctrl_word_t     w_idex_next;
    halt_state_e    w_state_next;
    logic [CntW-1:0] w_cnt_next;
    logic           w_unused_memwb;

    ctrl_word_t     r_idex;
    ctrl_word_t     r_exmem;
    ctrl_word_t     r_memwb;
    halt_state_e    r_state;
    logic [CntW-1:0] r_cnt;
    logic           r_illegal;

    ctrl_decoder #(
        .ENABLE_M(ENABLE_M)
    ) u_ctrl_decoder (
        .i_inst    (id_inst),
        .i_valid   (id_valid),
        .i_halt_req(halt_req),
        .o_ctrl    (w_id_ctrl),
        .o_use_rs1 (w_use_rs1),
        .o_use_rs2 (w_use_rs2),
        .o_illegal (w_illegal)
    );

    assign w_load_use = r_idex.mem_read && (r_idex.rd != 5'd0) &&
                        ((w_use_rs1 && (id_inst[19:15] == r_idex.rd)) ||
                         (w_use_rs2 && (id_inst[24:20] == r_idex.rd)));

    // Halt FSM next state: count non-stalled cycles after a halting ecall hits EX.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (!mem_stall) begin
            case (r_state)
                HaltRun: begin
                    if (r_idex.halt) begin
                        if (HALT_DRAIN <= 1) begin
                            w_state_next = HaltHalted;
                            w_cnt_next   = '0;
                        end else begin
                            w_state_next = HaltDrain;
                            w_cnt_next   = CntW'(HALT_DRAIN - 1);
                        end
                    end
                end
                HaltDrain: begin
                    // the decrement that reaches zero is the one that halts
                    if (r_cnt <= CntW'(1)) begin
                        w_state_next = HaltHalted;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt - CntW'(1);
                    end
                end
                HaltHalted: begin
                    w_state_next = HaltHalted;
                end
                default: begin
                    w_state_next = HaltRun;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    // ID/EX load selection and front-end enables, in priority order.
    always_comb begin
        w_idex_next   = r_idex;
        w_set_illegal = 1'b0;
        w_pc_write    = 1'b1;
        if (mem_stall) begin
            w_pc_write = 1'b0;
        end else if (r_state != HaltRun) begin
            w_pc_write  = 1'b0;
            w_idex_next = CtrlBubble;
        end else if (flush) begin
            w_idex_next = CtrlBubble;
        end else if (w_load_use) begin
            w_pc_write  = 1'b0;
            w_idex_next = CtrlBubble;
        end else if (w_illegal) begin
            w_idex_next   = CtrlBubble;
            w_set_illegal = 1'b1;
        end else begin
            w_idex_next = w_id_ctrl;
        end
        // reset keeps the front end fetching regardless of other inputs
        if (!reset) begin
            w_pc_write = 1'b1;
        end
    end

    // Stage registers advance together and freeze on a memory stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idex  <= CtrlBubble;
            r_exmem <= CtrlBubble;
            r_memwb <= CtrlBubble;
        end else if (!mem_stall) begin
            r_idex  <= w_idex_next;
            r_exmem <= r_idex;
            r_memwb <= r_exmem;
        end
    end

    // Halt FSM state and drain counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= HaltRun;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Sticky illegal-instruction flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_illegal <= 1'b0;
        end else if (w_set_illegal) begin
            r_illegal <= 1'b1;
        end
    end

    assign ex_alu_src      = r_idex.alu_src;
    assign ex_branch       = r_idex.branch;
    assign ex_is_jal       = r_idex.is_jal;
    assign ex_is_jalr      = r_idex.is_jalr;
    assign ex_alu_op       = r_idex.alu_op;
    assign ex_rd           = r_idex.rd;
    assign mem_read        = r_exmem.mem_read;
    assign mem_write       = r_exmem.mem_write;
    assign mem_rd          = r_exmem.rd;
    assign wb_write_enable = r_memwb.wb_write_enable;
    assign wb_mem_to_reg   = r_memwb.wb_mem_to_reg;
    assign wb_pc_to_reg    = r_memwb.wb_pc_to_reg;
    assign wb_rd           = r_memwb.rd;
    assign pc_write        = w_pc_write;
    assign ifid_write      = w_pc_write;
    assign is_halted       = (r_state == HaltHalted);
    assign illegal_inst    = r_illegal;

    // EX/MEM-only fields ride along into MEM/WB but are not consumed there
    assign w_unused_memwb = ^{r_memwb.alu_src, r_memwb.branch, r_memwb.is_jal,
                              r_memwb.is_jalr, r_memwb.alu_op, r_memwb.mem_read,
                              r_memwb.mem_write, r_memwb.halt};

endmodule

// File: doc/pipe_ctrl_unit.md
PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 SHALL have parameter ENABLE_M, default 0, meaning 1 = decode RV32M (funct7=0000001) R-type as ALU op MULDIV.
REQ-002 SHALL have parameter HALT_DRAIN, default 2, meaning non-stalled cycles from ecall-in-EX to is_halted.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous active-low reset.
REQ-006 SHALL have port id_inst  in  32  instruction in ID; opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20], funct7 [31:25].
REQ-007 SHALL have port id_valid  in  1  id_inst is a real instruction; 0 decodes as bubble.
REQ-008 SHALL have port mem_stall  in  1  cache not ready; freezes all control stages.
REQ-009 SHALL have port flush  in  1  EX redirect (taken branch/jump); ID instruction discarded.
REQ-010 SHALL have port halt_req  in  1  x17==10 at ecall decode.
REQ-011 SHALL have outputs ex_alu_src, ex_branch, ex_is_jal, ex_is_jalr (1 each) and ex_alu_op (3): ID/EX stage.
REQ-012 SHALL have outputs mem_read, mem_write (1 each): EX/MEM stage.
REQ-013 SHALL have outputs wb_write_enable, wb_mem_to_reg, wb_pc_to_reg (1 each): MEM/WB stage.
REQ-014 SHALL have outputs ex_rd, mem_rd, wb_rd  out  5  destination registers per stage.
REQ-015 SHALL have outputs pc_write, ifid_write  out  1  PC / IF-ID register enables.
REQ-016 SHALL have outputs is_halted  out  1 and illegal_inst  out  1 (sticky).

Function
REQ-017 SHALL decode opcodes: R 0110011, load 0000011, store 0100011, I 0010011, branch 1100011, jalr 1100111, jal 1101111, ecall 1110011; others are illegal.
REQ-018 SHALL encode ex_alu_op: 000 add (load/store/jal/jalr), 001 branch, 010 R, 011 I, 100 MULDIV.
REQ-019 SHALL, when ENABLE_M=0, treat R-type with funct7=0000001 as illegal.
REQ-020 SHALL, for a valid illegal instruction, inject a bubble and set illegal_inst to 1 until reset.
REQ-021 SHALL advance the control word ID->EX->MEM->WB one stage per non-stalled cycle; latency ID to WB is 3 cycles.
REQ-022 SHALL, while mem_stall=1, hold every stage register and the halt FSM, and drive pc_write=0, ifid_write=0.
REQ-023 SHALL detect load-use: EX mem_read=1, ex_rd!=0, and ex_rd equals an rs used by ID (rs1: R, I, load, store, branch, jalr; rs2: R, store, branch).
REQ-024 SHALL, on load-use without flush or stall, load a bubble into ID/EX and drive pc_write=0, ifid_write=0 for that cycle.
REQ-025 SHALL, on flush without stall, load a bubble into ID/EX with pc_write=1, ifid_write=1; flush overrides load-use.
REQ-026 SHALL apply priority: reset > mem_stall > halt FSM not RUN > flush > load-use > normal.
REQ-027 SHALL implement halt FSM RUN -> DRAIN -> HALTED, with a drain counter.
REQ-028 SHALL, in RUN, enter DRAIN with counter=HALT_DRAIN-1 when an ecall with halt_req=1 at decode sits in EX and mem_stall=0.
REQ-029 SHALL, in DRAIN, decrement the counter per non-stalled cycle; at 0 it SHALL enter HALTED and set is_halted=1.
REQ-030 SHALL, in DRAIN and HALTED, drive pc_write=0, ifid_write=0 and inject ID/EX bubbles; HALTED exits only on reset.
REQ-031 SHALL drop an ecall with halt_req=0 as a bubble without state change.

Reset
REQ-032 SHALL, on reset=0, clear all stage control bits and rd fields, is_halted and illegal_inst to 0, and FSM to RUN, counter to 0.
REQ-033 SHALL drive pc_write=1, ifid_write=1 in reset and after reset release.
REQ-034 SHALL abort in-flight DRAIN on reset asserted mid-operation.

Structure
REQ-035 SHALL place opcode constants, alu_op encodings, the control-word typedef and the halt-state enum in shared package ctrl_pkg.
REQ-036 SHALL isolate combinational decode in sub-module ctrl_decoder (inst, valid, ENABLE_M -> control word, rs usage, illegal).

Verification
REQ-037 SHALL cover: lw x5 then add x6,x5,x7 -> one cycle pc_write=0, ID/EX bubble, add reaches EX one cycle later.
REQ-038 SHALL cover: lw x5 with flush=1 in the hazard cycle -> bubble, pc_write=1.
REQ-039 SHALL cover: mem_stall=1 for 4 cycles mid-sw -> mem_write held at 1, all stage outputs unchanged.
REQ-040 SHALL cover: ecall, halt_req=1, HALT_DRAIN=2, stall 1 cycle in DRAIN -> is_halted=1 exactly 3 cycles after ecall in EX.
REQ-041 SHALL cover: mul x1,x2,x3 with ENABLE_M=1 -> ex_alu_op=100; with ENABLE_M=0 -> bubble, illegal_inst=1.
REQ-042 SHALL cover: reset=0 during DRAIN -> is_halted=0, FSM RUN, pc_write=1 immediately.
